// File: rtl/lc3b_types.sv
// -----------------------------------------------------------------------------
// lc3b_types
// Shared type definitions for the LC-3b datapath.
//   mem_state_t : sequencing states of the memory-stage access unit
//   mem_req_t   : one latched MEM-stage request. The flags come first, then the
//                 byte address and the store data.
// The addr/wdata fields are sized for the LC-3b machine word. Users with other
// widths size-cast into and out of the struct.
// -----------------------------------------------------------------------------
package lc3b_types;

    localparam int REQ_ADDR_WIDTH = 16;
    localparam int REQ_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic                      read;
        logic                      write;
        logic                      is_byte;
        logic                      sext;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for an N-byte-wide data memory.
// The instruction-fetch side also uses it for byte tests.
// Ports:
//   lane       in  byte lane selected by the low address bits
//   is_byte    in  1 = byte access, 0 = full-word access
//   is_write   in  access is a store; this affects only the mask
//   sext       in  byte load: 1 = sign-extend, 0 = zero-extend
//   wdata      in  store data; a byte store uses bits [7:0]
//   rdata      in  raw memory read data
//   store_data out write data with the byte replicated to every lane
//   store_mask out byte-lane write enables
//   load_data  out aligned and extended load result
// -----------------------------------------------------------------------------
module mem_lane_align #(
    parameter  int DATA_WIDTH = 16,
    localparam int LANES      = DATA_WIDTH / 8,
    localparam int LANE_BITS  = $clog2(LANES)
) (
    input  logic [LANE_BITS-1:0]  lane,
    input  logic                  is_byte,
    input  logic                  is_write,
    input  logic                  sext,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] store_data,
    output logic [LANES-1:0]      store_mask,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [7:0] lane_byte;

    // Replicating the byte to all lanes lets the mask alone decide where it
    // lands. Reads and word stores enable every lane.
    always_comb begin
        store_data = is_byte ? {LANES{wdata[7:0]}} : wdata;
        store_mask = '1;
        if (is_byte && is_write) begin
            store_mask       = '0;
            store_mask[lane] = 1'b1;
        end
    end

    // Pick the addressed byte out of the memory word, then extend it to the
    // full register width.
    always_comb begin
        lane_byte = 8'h00;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LANE_BITS'(i)) begin
                lane_byte = rdata[i*8 +: 8];
            end
        end
        load_data = is_byte ? {{(DATA_WIDTH-8){sext & lane_byte[7]}}, lane_byte}
                            : rdata;
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage access unit. It turns a MEM-stage load or store into a
// handshaked data-memory transaction. The request is latched and held stable
// until mem_resp. The unit stalls the pipeline while the access is
// outstanding. Aligned load data is returned one cycle after the response.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap word accesses whose low
// address bits are nonzero. Such an access skips memory and pulses
// misalign_fault. Without the macro, those addresses are silently aligned.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req_*           MEM-stage request (valid, read, write, byte, sext, addr, wdata)
//   stall_out       freezes pipeline stages up to and including MEM
//   load_valid      one-cycle pulse marking load_data valid
//   load_data       aligned load result (registered)
//   misalign_fault  one-cycle pulse for a trapped misaligned word access
//   mem_read/write  memory strobes
//   mem_address     memory byte address
//   mem_wdata       memory write data
//   mem_wmask       byte-lane write enables
//   mem_rdata       memory read data
//   mem_resp        memory completion pulse
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter  int DATA_WIDTH = 16,
    parameter  int ADDR_WIDTH = 16,
    localparam int LANES      = DATA_WIDTH / 8,
    localparam int LANE_BITS  = $clog2(LANES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic                  req_byte,
    input  logic                  req_sext,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall_out,
    output logic                  load_valid,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misalign_fault,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [LANES-1:0]      mem_wmask,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    import lc3b_types::*;

    mem_state_t            state_q;
    mem_state_t            state_d;
    mem_req_t              req_q;
    logic [DATA_WIDTH-1:0] load_data_q;
    logic                  req_ok;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] store_data;
    logic [LANES-1:0]      store_mask;
    logic [DATA_WIDTH-1:0] aligned_load;
    logic                  goto_done;

    // A request counts only when exactly one strobe is set. Both or neither
    // means there is no memory operation.
    assign req_ok = req_valid && (req_read ^ req_write);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned_req;
    logic fault_q;

    assign misaligned_req = !req_byte && (req_addr[LANE_BITS-1:0] != '0);
    assign goto_done      = misaligned_req;
    assign misalign_fault = (state_q == DONE) && fault_q;
    assign load_valid     = (state_q == DONE) && req_q.read && !fault_q;
`else
    assign goto_done      = 1'b0;
    assign misalign_fault = 1'b0;
    assign load_valid     = (state_q == DONE) && req_q.read;
`endif

    // Next state and control outputs. The stall is raised in the accept cycle
    // so the pipeline freezes before the request inputs can change. The
    // strobes come only from the latched request, and only while BUSY.
    always_comb begin
        state_d   = state_q;
        stall_out = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    accept    = 1'b1;
                    stall_out = 1'b1;
                    state_d   = goto_done ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall_out = 1'b1;
                mem_read  = req_q.read;
                mem_write = req_q.write;
                if (mem_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch and load-data capture. A response is only meaningful in
    // BUSY. A response that arrives after a reset or while idle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= '0;
            load_data_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                req_q.read    <= req_read;
                req_q.write   <= req_write;
                req_q.is_byte <= req_byte;
                req_q.sext    <= req_sext;
                req_q.addr    <= REQ_ADDR_WIDTH'(req_addr);
                req_q.wdata   <= REQ_DATA_WIDTH'(req_wdata);
`ifdef MEM_MISALIGN_TRAP_EN
                fault_q       <= misaligned_req;
`endif
            end
            if ((state_q == BUSY) && mem_resp && req_q.read) begin
                load_data_q <= aligned_load;
            end
        end
    end

    assign lat_addr  = ADDR_WIDTH'(req_q.addr);
    assign lat_wdata = DATA_WIDTH'(req_q.wdata);

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .lane       (lat_addr[LANE_BITS-1:0]),
        .is_byte    (req_q.is_byte),
        .is_write   (req_q.write),
        .sext       (req_q.sext),
        .wdata      (lat_wdata),
        .rdata      (mem_rdata),
        .store_data (store_data),
        .store_mask (store_mask),
        .load_data  (aligned_load)
    );

    // Word accesses go out on a word boundary. Byte accesses keep the full
    // address so that the memory sees the exact byte.
    assign mem_address = req_q.is_byte ? lat_addr
                                       : {lat_addr[ADDR_WIDTH-1:LANE_BITS], LANE_BITS'(0)};
    assign mem_wdata   = store_data;
    assign mem_wmask   = store_mask;
    assign load_data   = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit with the default 16-bit widths.
// Directed transactions carry hand-computed expectations. Random transactions
// take their expectations from a small behavioural model of the address, data,
// mask and load rules. One negedge process compares the DUT against the
// current expectations. Honours MEM_MISALIGN_TRAP_EN when it is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int LANES = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_read, req_write, req_byte, req_sext;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          stall_out, load_valid, misalign_fault, mem_read, mem_write;
    logic [DW-1:0] load_data, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_address;
    logic [LANES-1:0] mem_wmask;
    logic          mem_resp;

    int n_cmp  = 0;
    int n_fail = 0;

    logic          chk_en    = 1'b0;
    logic          chk_bus   = 1'b0;
    logic          chk_wdata = 1'b0;
    logic          chk_ld    = 1'b0;
    logic          e_stall, e_rd, e_wr, e_lv, e_fault;
    logic [15:0]   e_addr, e_wdata, e_ld;
    logic [1:0]    e_mask;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_read       (req_read),
        .req_write      (req_write),
        .req_byte       (req_byte),
        .req_sext       (req_sext),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall_out      (stall_out),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .misalign_fault (misalign_fault),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] modelAddr(input logic bt, input logic [15:0] a);
        return bt ? a : (a & ~16'(LANES - 1));
    endfunction

    function automatic logic [15:0] modelWdata(input logic bt, input logic [15:0] w);
        logic [15:0] r;
        if (!bt) return w;
        r = 16'h0;
        for (int i = 0; i < LANES; i++) r = r | (16'(w[7:0]) << (8 * i));
        return r;
    endfunction

    function automatic logic [1:0] modelMask(input logic bt, input logic wr, input logic [15:0] a);
        if (bt && wr) return 2'(1 << (int'(a) % LANES));
        return 2'b11;
    endfunction

    function automatic logic [15:0] modelLoad(input logic bt, input logic sx,
                                              input logic [15:0] a, input logic [15:0] rd);
        int b;
        if (!bt) return rd;
        b = (int'(rd) >> (8 * (int'(a) % LANES))) & 'hFF;
        if (sx && b >= 128) b = b - 256;
        return 16'(b);
    endfunction

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("stall_out",      32'(stall_out),      32'(e_stall));
            checkOutput("mem_read",       32'(mem_read),       32'(e_rd));
            checkOutput("mem_write",      32'(mem_write),      32'(e_wr));
            checkOutput("load_valid",     32'(load_valid),     32'(e_lv));
            checkOutput("misalign_fault", 32'(misalign_fault), 32'(e_fault));
            if (chk_bus) begin
                checkOutput("mem_address", 32'(mem_address), 32'(e_addr));
                checkOutput("mem_wmask",   32'(mem_wmask),   32'(e_mask));
            end
            if (chk_wdata) checkOutput("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            if (chk_ld)    checkOutput("load_data", 32'(load_data), 32'(e_ld));
        end
    end

    task automatic expectCtl(input logic s, input logic r, input logic w,
                             input logic lv, input logic f);
        e_stall = s; e_rd = r; e_wr = w; e_lv = lv; e_fault = f;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // One complete MEM-stage instruction, entered one step after a rising edge
    // with the unit idle. The x_* arguments are the expected bus and load values.
    task automatic applyStimulus(input logic rd, input logic wr, input logic bt, input logic sx,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] rdata, input int waitc,
                                 input logic [15:0] x_addr, input logic [15:0] x_wdata,
                                 input logic [15:0] x_ld, input logic [1:0] x_mask);
        logic valid;
        logic trap;
        valid = rd ^ wr;
        trap  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap  = valid && !bt && (addr[0] != 1'b0);
`endif
        req_valid = 1'b1; req_read = rd; req_write = wr; req_byte = bt; req_sext = sx;
        req_addr = addr; req_wdata = wdata; mem_resp = 1'b0; mem_rdata = 16'($urandom);
        chk_bus = 1'b0; chk_wdata = 1'b0; chk_ld = 1'b0;
        expectCtl(valid, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle;
        if (!valid) begin
            req_valid = 1'b0;
            expectCtl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            nextCycle;
            return;
        end
        if (trap) begin
            expectCtl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            nextCycle;
        end else begin
            for (int k = 0; k <= waitc; k++) begin
                mem_resp  = (k == waitc);
                mem_rdata = (k == waitc) ? rdata : 16'($urandom);
                expectCtl(1'b1, rd, wr, 1'b0, 1'b0);
                chk_bus = 1'b1; chk_wdata = wr;
                e_addr = x_addr; e_wdata = x_wdata; e_mask = x_mask;
                nextCycle;
            end
            mem_resp = 1'b0; mem_rdata = 16'($urandom);
            chk_bus = 1'b0; chk_wdata = 1'b0;
            expectCtl(1'b0, 1'b0, 1'b0, rd, 1'b0);
            chk_ld = rd; e_ld = x_ld;
            nextCycle;
        end
        // Idle gap with a possible spurious response, which must be ignored.
        req_valid = 1'b0; chk_ld = 1'b0; mem_resp = 1'($urandom_range(0, 1));
        expectCtl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle;
        mem_resp = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       rd, wr, bt, sx;
        logic [15:0] a, w, r;
        int          sel, wt;

        rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_sext = 1'b0; req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
        nextCycle;
        // Reset state: everything zero except an all-ones write mask.
        expectCtl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_bus = 1'b1; chk_wdata = 1'b1; chk_ld = 1'b1;
        e_addr = 16'h0; e_wdata = 16'h0; e_mask = 2'b11; e_ld = 16'h0;
        chk_en = 1'b1;
        nextCycle;
        rst = 1'b0; chk_bus = 1'b0; chk_wdata = 1'b0; chk_ld = 1'b0;
        nextCycle;

        // Directed cases with hand-computed expectations.
        applyStimulus(1, 0, 0, 0, 16'h1004, 16'h0000, 16'hBEEF, 0, 16'h1004, 16'h0000, 16'hBEEF, 2'b11);
        applyStimulus(0, 1, 1, 0, 16'h2001, 16'h00A5, 16'h0000, 3, 16'h2001, 16'hA5A5, 16'h0000, 2'b10);
        applyStimulus(1, 0, 1, 1, 16'h3000, 16'h0000, 16'h1280, 1, 16'h3000, 16'h0000, 16'hFF80, 2'b11);
        applyStimulus(1, 0, 1, 0, 16'h3000, 16'h0000, 16'h1280, 0, 16'h3000, 16'h0000, 16'h0080, 2'b11);
        applyStimulus(1, 0, 1, 0, 16'h3001, 16'h0000, 16'h1280, 2, 16'h3001, 16'h0000, 16'h0012, 2'b11);
        applyStimulus(1, 1, 0, 0, 16'h1234, 16'h5555, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 2'b11);
        applyStimulus(0, 0, 0, 0, 16'h1234, 16'h5555, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 2'b11);
        applyStimulus(0, 1, 0, 0, 16'h6006, 16'hC3D2, 16'h0000, 1, 16'h6006, 16'hC3D2, 16'h0000, 2'b11);
        applyStimulus(1, 0, 0, 0, 16'h4003, 16'h0000, 16'h7777, 0, 16'h4002, 16'h0000, 16'h7777, 2'b11);

        // Reset while BUSY: the late response must be ignored.
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_byte = 1'b0;
        req_addr = 16'h5000; mem_resp = 1'b0;
        expectCtl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle;
        expectCtl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_bus = 1'b1; e_addr = 16'h5000; e_mask = 2'b11;
        nextCycle;
        rst = 1'b1;
        nextCycle;
        rst = 1'b0; req_valid = 1'b0; mem_resp = 1'b1; mem_rdata = 16'hDEAD;
        expectCtl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_addr = 16'h0000; e_mask = 2'b11; chk_wdata = 1'b1; e_wdata = 16'h0000;
        nextCycle;
        mem_resp = 1'b0; chk_bus = 1'b0; chk_wdata = 1'b0;
        nextCycle;

        // Randomized transactions checked against the model.
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 7);
            rd  = 1'($urandom_range(0, 1));
            wr  = !rd;
            if (sel == 0) begin rd = 1'b1; wr = 1'b1; end
            if (sel == 1) begin rd = 1'b0; wr = 1'b0; end
            bt = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            w  = 16'($urandom);
            r  = 16'($urandom);
            wt = $urandom_range(0, 3);
            applyStimulus(rd, wr, bt, sx, a, w, r, wt,
                          modelAddr(bt, a), modelWdata(bt, w),
                          modelLoad(bt, sx, a, r), modelMask(bt, wr, a));
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
